fwft_fifo: RTL and testbench

Synchronous single-clock first-word-fall-through FIFO. It buffers `DATA_WIDTH`-bit words between a producer that pushes with `wr_en`/`full` and a consumer that sees the head word on `dout` whenever `empty` is low. It is built as a standard registered-read FIFO core followed by a one-word prefetch (output) register.

---
 rtl/fwft_fifo_pkg.sv | 17 +
 rtl/fifo_core.sv | 58 +++++
 rtl/fwft_fifo.sv | 76 +++++++
 tb/tb_fwft_fifo.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fwft_fifo_pkg.sv
// rtl/fwft_fifo_pkg.sv - shared width helpers for the FWFT FIFO and its core
package fwft_fifo_pkg;

  localparam int DEF_DEPTH_WIDTH = 4;
  localparam int DEF_DATA_WIDTH  = 16;

  // One extra pointer bit separates full from empty
  function automatic int ptr_width(input int depth_width);
    return depth_width + 1;
  endfunction

  // Must hold 0..2^depth_width+1 (core plus output register)
  function automatic int count_width(input int depth_width);
    return depth_width + 2;
  endfunction

endpackage

// File: rtl/fifo_core.sv
// rtl/fifo_core.sv - single-clock FIFO with registered read data
module fifo_core
  import fwft_fifo_pkg::*;
#(
  parameter int DEPTH_WIDTH = DEF_DEPTH_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_wr_en,
  output logic                  o_full,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_empty
);

  localparam int PW = ptr_width(DEPTH_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [2**DEPTH_WIDTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr;
  logic                  w_rd;

  assign w_full  = (r_wptr[DEPTH_WIDTH] != r_rptr[DEPTH_WIDTH]) &&
                   (r_wptr[DEPTH_WIDTH-1:0] == r_rptr[DEPTH_WIDTH-1:0]);
  assign w_empty = (r_wptr == r_rptr);
  assign w_wr    = i_wr_en & ~w_full;
  assign w_rd    = i_rd_en & ~w_empty;

  // RAM contents survive reset
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[DEPTH_WIDTH-1:0]] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_rdata <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) begin
        r_rptr  <= r_rptr + 1'b1;
        r_rdata <= r_mem[r_rptr[DEPTH_WIDTH-1:0]];
      end
    end
  end

  assign o_full    = w_full;
  assign o_empty   = w_empty;
  assign o_rd_data = r_rdata;

endmodule

// File: rtl/fwft_fifo.sv
// rtl/fwft_fifo.sv - first-word-fall-through FIFO; optional count port under FWFT_FIFO_COUNT_EN
module fwft_fifo
  import fwft_fifo_pkg::*;
#(
  parameter int DEPTH_WIDTH = DEF_DEPTH_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic                  rd_en,
  output logic                  empty
`ifdef FWFT_FIFO_COUNT_EN
  ,
  output logic [count_width(DEPTH_WIDTH)-1:0] count
`endif
);

  logic w_core_empty;
  logic w_rd_issue;
  logic r_dout_valid;

  // The core's registered read data doubles as the prefetch (output) register
  assign w_rd_issue = ~w_core_empty & (~r_dout_valid | rd_en);

  fifo_core #(
    .DEPTH_WIDTH(DEPTH_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .i_wr_data(din),
    .i_wr_en  (wr_en),
    .o_full   (full),
    .i_rd_en  (w_rd_issue),
    .o_rd_data(dout),
    .o_empty  (w_core_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout_valid <= 1'b0;
    end else if (w_rd_issue) begin
      r_dout_valid <= 1'b1;
    end else if (rd_en) begin
      r_dout_valid <= 1'b0;
    end
  end

  assign empty = ~r_dout_valid;

`ifdef FWFT_FIFO_COUNT_EN
  localparam int CW = count_width(DEPTH_WIDTH);

  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] r_count;

  assign w_push = wr_en & ~full;
  assign w_pop  = rd_en & r_dout_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign count = r_count;
`endif

endmodule

// File: tb/tb_fwft_fifo.sv
// tb/tb_fwft_fifo.sv - randomized self-checking bench for fwft_fifo against a queue model
module tb_fwft_fifo;

  logic        clk;
  logic        rst;
  logic [15:0] din;
  logic        wr_en;
  logic        full;
  logic [15:0] dout;
  logic        rd_en;
  logic        empty;
`ifdef FWFT_FIFO_COUNT_EN
  logic [5:0]  count;
`endif

  int errors;
  int checks;
  logic [15:0] q[$];
  logic push_ok;
  logic pop_ok;
  int n_rx;

  fwft_fifo #(.DEPTH_WIDTH(4), .DATA_WIDTH(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .wr_en(wr_en),
    .full (full),
    .dout (dout),
    .rd_en(rd_en),
    .empty(empty)
`ifdef FWFT_FIFO_COUNT_EN
    ,
    .count(count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: drive, judge acceptance at negedge, update model, land at posedge+1
  task automatic step(input logic we, input logic [15:0] d, input logic re);
    wr_en = we;
    din   = d;
    rd_en = re;
    @(negedge clk);
    if (q.size() == 0) begin
      checks++;
      if (empty !== 1'b1) begin
        errors++;
        $display("FAIL empty_when_model_empty: got %b want 1", empty);
      end
    end
`ifdef FWFT_FIFO_COUNT_EN
    checks++;
    if (count !== 6'(q.size())) begin
      errors++;
      $display("FAIL count: got %0d want %0d", count, q.size());
    end
`endif
    push_ok = we && !full;
    pop_ok  = re && !empty;
    if (pop_ok) begin
      checks++;
      n_rx++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL pop_data: got %h want <nothing stored>", dout);
      end else begin
        if (dout !== q[0]) begin
          errors++;
          $display("FAIL pop_data: got %h want %h", dout, q[0]);
        end
        void'(q.pop_front());
      end
    end
    if (push_ok) q.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while (q.size() > 0 && c < budget) begin
      step(1'b0, 16'h0, 1'b1);
      c++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words left want 0", q.size());
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (dout !== 16'h0) begin errors++; $display("FAIL reset_dout: got %h want 0000", dout); end
    rst = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b1; din = 16'hA5A5;
    @(posedge clk); #1;
    wr_en = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL first_word_edge_k: got empty=%b want 1", empty); end
    @(posedge clk); #1;
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL first_word_empty: got %b want 0", empty); end
    checks++; if (dout !== 16'hA5A5) begin errors++; $display("FAIL first_word_dout: got %h want a5a5", dout); end
    q.push_back(16'hA5A5);
    step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_fill;
    int acc;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 16'($urandom), 1'b0);
      if (push_ok) acc++;
    end
    checks++; if (acc != 17) begin errors++; $display("FAIL fill_accepted: got %0d want 17", acc); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", full); end
    drain(60);
    step(1'b0, 16'h0, 1'b0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_final_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_final_full: got %b want 0", full); end
  endtask

  task automatic test_underflow;
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL underflow_empty: got %b want 1", empty); end
    for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h1000 + i), 1'b0);
    drain(40);
  endtask

  task automatic test_stream;
    int sent;
    int cyc;
    int rx0;
    sent = 0; cyc = 0; rx0 = n_rx;
    while ((n_rx - rx0) < 128 && cyc < 400) begin
      step(sent < 128, 16'($urandom), 1'b1);
      if (push_ok) sent++;
      cyc++;
    end
    checks++; if ((n_rx - rx0) != 128) begin errors++; $display("FAIL stream_count: got %0d want 128", n_rx - rx0); end
    checks++; if (cyc > 134) begin errors++; $display("FAIL stream_throughput: got %0d cycles want <=134", cyc); end
  endtask

  task automatic test_random_rates;
    int rates[3] = '{30, 70, 100};
    logic [15:0] blk[128];
    int si;
    int cyc;
    int rx0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 128; i++) blk[i] = 16'($urandom);
      si = 0; cyc = 0; rx0 = n_rx;
      while ((n_rx - rx0) < 128 && cyc < 3000) begin
        step((si < 128) && ($urandom_range(99) < rates[r]), blk[si < 128 ? si : 0],
             $urandom_range(1) == 1);
        if (push_ok) si++;
        cyc++;
      end
      checks++;
      if ((n_rx - rx0) != 128) begin
        errors++;
        $display("FAIL random_rate_%0d_count: got %0d want 128", rates[r], n_rx - rx0);
      end
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 8; i++) step(1'b1, 16'($urandom), 1'b0);
    #2 rst = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midreset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL midreset_full: got %b want 0", full); end
    checks++; if (dout !== 16'h0) begin errors++; $display("FAIL midreset_dout: got %h want 0000", dout); end
    q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    step(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 16'(16'hC0DE + i), 1'b0);
    drain(30);
  endtask

  initial begin
    errors = 0; checks = 0; n_rx = 0;
    test_reset;
    test_fill;
    test_underflow;
    test_stream;
    test_random_rates;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
